axis_cic_integrator_chain: RTL and testbench



---
 rtl/axis_cic_integrator_chain.sv | 118 +++++++++++
 tb/tb_axis_cic_integrator_chain.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_cic_integrator_chain.sv
// -----------------------------------------------------------------------------
// axis_cic_integrator_chain
//
// Purpose:
//   Cascade of N_STAGES pipelined integrators forming the integrator section of
//   a CIC interpolator/decimator. AXI-Stream in and out with full backpressure.
//   Input samples are sign-extended to CIC_WIDTH. Accumulation is modular
//   (wrap-around, no saturation) because the downstream comb section depends on
//   two's-complement wrap cancelling out.
//
// Parameters:
//   WIDTH      input sample width (two's complement)
//   N_STAGES   number of cascaded integrators (1..8)
//   GROWTH     register growth bits
//   SIGN       extra guard/sign bit
//   CIC_WIDTH  accumulator/output width = WIDTH + GROWTH + SIGN (derived)
//
// Ports:
//   aclk                clock
//   arst                synchronous active-high reset
//   s_axis_data_tdata   input sample (signed, WIDTH bits)
//   s_axis_data_tvalid  input valid
//   s_axis_data_tready  input ready (= global pipeline advance)
//   m_axis_data_tdata   output sample = last-stage accumulator (CIC_WIDTH bits)
//   m_axis_data_tvalid  output valid
//   m_axis_data_tready  downstream ready
//   intg_clear          accumulator flush (only with CIC_INTG_CLEAR_EN)
//
// Configuration macro:
//   CIC_INTG_CLEAR_EN   adds the intg_clear port. A clear at a rising edge
//                       zeroes every accumulator and stage valid, dropping any
//                       in-flight or pending output. Priority: arst > intg_clear
//                       > normal advance.
// -----------------------------------------------------------------------------
module axis_cic_integrator_chain #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned N_STAGES  = 3,
   parameter int unsigned GROWTH    = 7,
   parameter int unsigned SIGN      = 1,
   localparam int unsigned CIC_WIDTH = WIDTH + GROWTH + SIGN
) (
   input  logic                 aclk,
   input  logic                 arst,
`ifdef CIC_INTG_CLEAR_EN
   input  logic                 intg_clear,
`endif
   input  logic [WIDTH-1:0]     s_axis_data_tdata,
   input  logic                 s_axis_data_tvalid,
   output logic                 s_axis_data_tready,
   output logic [CIC_WIDTH-1:0] m_axis_data_tdata,
   output logic                 m_axis_data_tvalid,
   input  logic                 m_axis_data_tready
);

   // Per-stage accumulators and slot valids. Stage N_STAGES-1 is the output
   // register, so the chain has exactly N_STAGES register stages of latency.
   logic [CIC_WIDTH-1:0] acc_q [N_STAGES];
   logic [CIC_WIDTH-1:0] acc_d [N_STAGES];
   logic [N_STAGES-1:0]  v_q;
   logic [N_STAGES-1:0]  v_d;

   logic                 ce;
   logic                 flush;
   logic [CIC_WIDTH-1:0] x_ext;

   // The whole chain moves in lockstep: it advances whenever the output slot is
   // empty or being consumed. Bubbles travel as invalid slots rather than being
   // squeezed out, which keeps the control to a single enable.
   assign ce = ~v_q[N_STAGES-1] | m_axis_data_tready;
   assign s_axis_data_tready = ce;

   assign x_ext = CIC_WIDTH'($signed(s_axis_data_tdata));

`ifdef CIC_INTG_CLEAR_EN
   assign flush = intg_clear;
`else
   assign flush = 1'b0;
`endif

   // Next-state: each stage integrates only when its upstream slot is valid, so
   // the output equals an ideal cascade integrator over accepted samples only.
   always_comb begin
      acc_d = acc_q;
      v_d   = v_q;
      if (ce) begin
         v_d[0] = s_axis_data_tvalid;
         if (s_axis_data_tvalid) begin
            acc_d[0] = acc_q[0] + x_ext;
         end
         for (int k = 1; k < int'(N_STAGES); k++) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               // Stage k sees stage k-1's value from before this edge, which is
               // already the updated sum for the sample now moving into stage k.
               acc_d[k] = acc_q[k] + acc_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (arst || flush) begin
         for (int k = 0; k < int'(N_STAGES); k++) begin
            acc_q[k] <= '0;
         end
         v_q <= '0;
      end else begin
         for (int k = 0; k < int'(N_STAGES); k++) begin
            acc_q[k] <= acc_d[k];
         end
         v_q <= v_d;
      end
   end

   assign m_axis_data_tdata  = acc_q[N_STAGES-1];
   assign m_axis_data_tvalid = v_q[N_STAGES-1];

endmodule

// File: tb/tb_axis_cic_integrator_chain.sv
// -----------------------------------------------------------------------------
// tb_axis_cic_integrator_chain
//
// Scoreboard bench. Main DUT uses default parameters (N=3, 24-bit accumulators).
// Each accepted beat advances an ideal cascade-integrator model whose last-stage
// value is queued; each output handshake pops and compares. Two tiny extra
// instances cover 4-bit wrap and sign extension with fixed expected values.
// -----------------------------------------------------------------------------
module tb_axis_cic_integrator_chain;

   localparam int unsigned N  = 3;
   localparam int unsigned W  = 16;
   localparam int unsigned CW = 24;

   logic          clk = 1'b0;
   logic          arst;
   logic [W-1:0]  s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic [CW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready;
`ifdef CIC_INTG_CLEAR_EN
   logic          intg_clear;
`endif

   // Wrap instance: WIDTH=4, GROWTH=0, SIGN=0, N=1.
   logic [3:0] w_data;
   logic [3:0] w_out;
   logic       w_out_v;
   logic       w_sready;
   // Sign-extension instance: WIDTH=4, GROWTH=4, SIGN=0, N=1.
   logic [3:0] e_data;
   logic [7:0] e_out;
   logic       e_out_v;
   logic       e_sready;
   logic       x_valid;
   logic       x_ready;

   always #5 clk = ~clk;

   axis_cic_integrator_chain u_dut (
      .aclk               (clk),
      .arst               (arst),
`ifdef CIC_INTG_CLEAR_EN
      .intg_clear         (intg_clear),
`endif
      .s_axis_data_tdata  (s_tdata),
      .s_axis_data_tvalid (s_tvalid),
      .s_axis_data_tready (s_tready),
      .m_axis_data_tdata  (m_tdata),
      .m_axis_data_tvalid (m_tvalid),
      .m_axis_data_tready (m_tready)
   );

   axis_cic_integrator_chain #(.WIDTH(4), .N_STAGES(1), .GROWTH(0), .SIGN(0)) u_wrap (
      .aclk               (clk),
      .arst               (arst),
`ifdef CIC_INTG_CLEAR_EN
      .intg_clear         (1'b0),
`endif
      .s_axis_data_tdata  (w_data),
      .s_axis_data_tvalid (x_valid),
      .s_axis_data_tready (w_sready),
      .m_axis_data_tdata  (w_out),
      .m_axis_data_tvalid (w_out_v),
      .m_axis_data_tready (x_ready)
   );

   axis_cic_integrator_chain #(.WIDTH(4), .N_STAGES(1), .GROWTH(4), .SIGN(0)) u_sext (
      .aclk               (clk),
      .arst               (arst),
`ifdef CIC_INTG_CLEAR_EN
      .intg_clear         (1'b0),
`endif
      .s_axis_data_tdata  (e_data),
      .s_axis_data_tvalid (x_valid),
      .s_axis_data_tready (e_sready),
      .m_axis_data_tdata  (e_out),
      .m_axis_data_tvalid (e_out_v),
      .m_axis_data_tready (x_ready)
   );

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            acc_cyc;
   int            first_v;
   logic [CW-1:0] mdl [N];
   logic [CW-1:0] exp_q [$];
   logic [CW-1:0] got_q [$];
   logic          stall_prev;
   logic [CW-1:0] held;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < int'(N); k++) mdl[k] = '0;
      exp_q.delete();
      stall_prev = 1'b0;
   endtask

   // Ideal cascade integrator, advanced once per accepted sample.
   task automatic model_push(input logic [W-1:0] din);
      mdl[0] = mdl[0] + CW'($signed(din));
      for (int k = 1; k < int'(N); k++) mdl[k] = mdl[k] + mdl[k-1];
      exp_q.push_back(mdl[N-1]);
   endtask

   task automatic start_phase();
      acc_cyc = -1;
      first_v = -1;
      got_q.delete();
   endtask

   // One clock: drive at the falling edge, observe 1ns later (stable until the
   // next rising edge, which is where the handshakes take effect).
   task automatic cycle(input logic rst, input logic clr, input logic vin,
                        input logic [W-1:0] din, input logic rdy);
      logic [CW-1:0] e;
      @(negedge clk);
      arst = rst;
`ifdef CIC_INTG_CLEAR_EN
      intg_clear = clr;
`endif
      s_tvalid = vin;
      s_tdata  = din;
      m_tready = rdy;
      #1;
      cyc++;
      if (rst || clr) begin
         model_clear();
      end else begin
         check_val("s_tready", s_tready, !(m_tvalid && !m_tready));
         if (stall_prev) begin
            check_val("hold_valid", m_tvalid, 1);
            check_val("hold_data", m_tdata, held);
         end
         if (vin && s_tready) begin
            model_push(din);
            if (acc_cyc < 0) acc_cyc = cyc;
         end
         if (m_tvalid && first_v < 0) first_v = cyc;
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_val("data", m_tdata, e);
               got_q.push_back(m_tdata);
            end
         end
         stall_prev = m_tvalid && !m_tready;
         held       = m_tdata;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle(0, 0, 0, '0, 1);
      check_val("drain_empty", exp_q.size(), 0);
      repeat (N + 1) cycle(0, 0, 0, '0, 1);
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, '0, 1);
      cycle(0, 0, 0, '0, 1);
   endtask

   task automatic check_table(input string tag, input int idx, input logic [CW-1:0] exp);
      logic [CW-1:0] g;
      g = (idx < got_q.size()) ? got_q[idx] : 'x;
      check_val(tag, g, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      arst     = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      m_tready = 1'b0;
`ifdef CIC_INTG_CLEAR_EN
      intg_clear = 1'b0;
`endif
      x_valid = 1'b0;
      x_ready = 1'b1;
      w_data  = '0;
      e_data  = '0;
      model_clear();

      // Reset state; ready is high out of reset even with downstream not ready.
      cycle(1, 0, 0, '0, 1);
      cycle(1, 0, 0, '0, 1);
      cycle(0, 0, 0, '0, 0);
      check_val("rst_valid", m_tvalid, 0);
      check_val("rst_data", m_tdata, 0);
      check_val("rst_ready", s_tready, 1);

      // Impulse: 1,3,6,10,15 with N-cycle latency.
      start_phase();
      cycle(0, 0, 1, 16'd1, 1);
      repeat (7) cycle(0, 0, 1, 16'd0, 1);
      drain();
      check_val("impulse_latency", first_v - acc_cyc, N);
      check_table("impulse_0", 0, 24'd1);
      check_table("impulse_1", 1, 24'd3);
      check_table("impulse_2", 2, 24'd6);
      check_table("impulse_3", 3, 24'd10);
      check_table("impulse_4", 4, 24'd15);

      // Constant 1 with downstream ready pattern 1,0,0,1.
      do_reset();
      start_phase();
      for (int i = 0; i < 16; i++) cycle(0, 0, 1, 16'd1, (i % 4 == 0) || (i % 4 == 3));
      drain();
      check_table("stall_0", 0, 24'd1);
      check_table("stall_1", 1, 24'd4);
      check_table("stall_2", 2, 24'd10);
      check_table("stall_3", 3, 24'd20);

      // Input gaps: 1, idle x3, 1, 1 -> exactly three outputs.
      do_reset();
      start_phase();
      cycle(0, 0, 1, 16'd1, 1);
      repeat (3) cycle(0, 0, 0, 16'd0, 1);
      cycle(0, 0, 1, 16'd1, 1);
      cycle(0, 0, 1, 16'd1, 1);
      drain();
      check_val("gap_count", got_q.size(), 3);
      check_table("gap_0", 0, 24'd1);
      check_table("gap_1", 1, 24'd4);
      check_table("gap_2", 2, 24'd10);

      // Random data, valid and ready; full-range samples exercise wrap.
      do_reset();
      start_phase();
      for (int i = 0; i < 300; i++)
         cycle(0, 0, ($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0);
      drain();

      // Reset mid-stream after 5 samples, then a fresh stream from zero.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 16'd1, 1);
      cycle(1, 0, 0, '0, 1);
      cycle(0, 0, 0, '0, 1);
      check_val("midrst_valid", m_tvalid, 0);
      check_val("midrst_data", m_tdata, 0);
      start_phase();
      repeat (3) cycle(0, 0, 1, 16'd1, 1);
      drain();
      check_table("midrst_0", 0, 24'd1);
      check_table("midrst_1", 1, 24'd4);
      check_table("midrst_2", 2, 24'd10);

`ifdef CIC_INTG_CLEAR_EN
      // Clear mid-stream while the output is stalled.
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 16'd1, 1);
      cycle(0, 0, 0, '0, 0);
      cycle(0, 1, 1, 16'd1, 0);
      cycle(0, 0, 0, '0, 1);
      check_val("clear_valid", m_tvalid, 0);
      check_val("clear_data", m_tdata, 0);
      start_phase();
      repeat (3) cycle(0, 0, 1, 16'd1, 1);
      drain();
      check_table("clear_0", 0, 24'd1);
      check_table("clear_1", 1, 24'd4);
      check_table("clear_2", 2, 24'd10);
`endif

      // 4-bit wrap (7,7 -> 7,E) and sign extension (-1,-1 -> FF,FE).
      @(negedge clk);
      x_valid = 1'b1;
      w_data  = 4'h7;
      e_data  = 4'hF;
      @(negedge clk);
      #1;
      check_val("wrap_v0", w_out_v, 1);
      check_val("wrap_0", w_out, 4'h7);
      check_val("sext_0", e_out, 8'hFF);
      @(negedge clk);
      x_valid = 1'b0;
      #1;
      check_val("wrap_1", w_out, 4'hE);
      check_val("sext_1", e_out, 8'hFE);
      @(negedge clk);
      #1;
      check_val("wrap_idle_v", w_out_v, 0);
      check_val("wrap_hold", w_out, 4'hE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
